tx_ram_sequencer: RTL

Sequences a frame transmission out of the shared 1000-byte message RAM and shares that RAM's single port between the SPI host and itself. On a rising edge of the transmit request from the SPI register block, it emits a fixed preamble, a sync byte, then msg_length payload bytes read from RAM, over a valid/ready byte stream to the modulator. It then pulses tx_done, which clears the transmit register.

---
 rtl/tx_ram_sequencer_pkg.sv | 20 ++
 rtl/tx_ram_sequencer_if.sv | 38 +++
 rtl/tx_ram_sequencer_arb.sv | 37 +++
 rtl/tx_ram_sequencer.sv | 111 +++++++++++
 4 files changed

// File: rtl/tx_ram_sequencer_pkg.sv
// Shared types and defaults for the transmit RAM sequencer.
package tx_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SYNC,
        FETCH,
        WAIT,
        SEND,
        DONE
    } state_t;

    localparam int         DEF_ADDR_W        = 10;
    localparam int         DEF_MAX_LEN       = 1000;
    localparam int         DEF_PREAMBLE_LEN  = 4;
    localparam logic [7:0] DEF_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] DEF_SYNC_BYTE     = 8'h96;

endpackage

// File: rtl/tx_ram_sequencer_if.sv
// SPI host bus, message RAM port and modulator byte stream seen from the sequencer.
interface tx_ram_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              i_spi_rd;
    logic              i_spi_wr;
    logic [ADDR_W-1:0] i_spi_addr;
    logic [7:0]        i_spi_wdata;
    logic [7:0]        o_spi_rdata;

    logic              o_ram_en;
    logic              o_ram_we;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [7:0]        o_ram_wdata;
    logic [7:0]        i_ram_rdata;

    logic [7:0]        o_byte;
    logic              o_byte_valid;
    logic              i_byte_ready;

    modport master (
        input  i_spi_rd, i_spi_wr, i_spi_addr, i_spi_wdata,
        output o_spi_rdata,
        output o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
        input  i_ram_rdata,
        output o_byte, o_byte_valid,
        input  i_byte_ready
    );

    modport slave (
        output i_spi_rd, i_spi_wr, i_spi_addr, i_spi_wdata,
        input  o_spi_rdata,
        input  o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
        output i_ram_rdata,
        input  o_byte, o_byte_valid,
        output i_byte_ready
    );
endinterface

// File: rtl/tx_ram_sequencer_arb.sv
// Single-port RAM mux: SPI write > SPI read > sequencer fetch. SPI is never stalled.
module ram_port_arb #(
    parameter int ADDR_W = 10
) (
    input  logic              spi_rd,
    input  logic              spi_wr,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [7:0]        spi_wdata,
    input  logic              seq_req,
    input  logic [ADDR_W-1:0] seq_addr,
    output logic              seq_gnt,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata
);
    always_comb begin
        seq_gnt   = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (spi_wr) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = spi_addr;
            ram_wdata = spi_wdata;
        end else if (spi_rd) begin
            ram_en   = 1'b1;
            ram_addr = spi_addr;
        end else if (seq_req) begin
            ram_en   = 1'b1;
            ram_addr = seq_addr;
            seq_gnt  = 1'b1;
        end
    end
endmodule

// File: rtl/tx_ram_sequencer.sv
// Frame transmitter: preamble, sync, then payload fetched from the shared message RAM.
module tx_ram_sequencer
    import tx_seq_pkg::*;
#(
    parameter int         ADDR_W        = DEF_ADDR_W,
    parameter int         MAX_LEN       = DEF_MAX_LEN,
    parameter int         PREAMBLE_LEN  = DEF_PREAMBLE_LEN,
    parameter logic [7:0] PREAMBLE_BYTE = DEF_PREAMBLE_BYTE,
    parameter logic [7:0] SYNC_BYTE     = DEF_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_transmit,
    input  logic [ADDR_W-1:0] i_msg_length,
    tx_ram_sequencer_if.master bus,
    output logic              o_busy,
    output logic              o_tx_done
);
    state_t            state, state_nxt;
    logic              transmit_d;
    logic              start;
    logic [ADDR_W-1:0] len, len_clamped;
    logic [ADDR_W-1:0] cnt, cnt_inc;
    logic [7:0]        byte_reg;
    logic              last_pre;
    logic              seq_req, seq_gnt;

    assign start       = i_transmit & ~transmit_d;
    assign len_clamped = (int'(i_msg_length) > MAX_LEN) ? ADDR_W'(MAX_LEN) : i_msg_length;
    assign cnt_inc     = cnt + 1'b1;
    assign last_pre    = (int'(cnt) + 1 >= PREAMBLE_LEN);
    assign o_busy      = (state != IDLE);
    assign bus.o_spi_rdata = bus.i_ram_rdata;

    ram_port_arb #(.ADDR_W(ADDR_W)) u_arb (
        .spi_rd    (bus.i_spi_rd),
        .spi_wr    (bus.i_spi_wr),
        .spi_addr  (bus.i_spi_addr),
        .spi_wdata (bus.i_spi_wdata),
        .seq_req   (seq_req),
        .seq_addr  (cnt),
        .seq_gnt   (seq_gnt),
        .ram_en    (bus.o_ram_en),
        .ram_we    (bus.o_ram_we),
        .ram_addr  (bus.o_ram_addr),
        .ram_wdata (bus.o_ram_wdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        bus.o_byte       = '0;
        bus.o_byte_valid = 1'b0;
        o_tx_done        = 1'b0;
        seq_req          = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = (PREAMBLE_LEN > 0) ? PRE : SYNC;
            PRE: begin
                bus.o_byte       = PREAMBLE_BYTE;
                bus.o_byte_valid = 1'b1;
                if (bus.i_byte_ready && last_pre) state_nxt = SYNC;
            end
            SYNC: begin
                bus.o_byte       = SYNC_BYTE;
                bus.o_byte_valid = 1'b1;
                if (bus.i_byte_ready) state_nxt = (len != '0) ? FETCH : DONE;
            end
            FETCH: begin
                seq_req = 1'b1;
                if (seq_gnt) state_nxt = WAIT;
            end
            WAIT: state_nxt = SEND;
            SEND: begin
                bus.o_byte       = byte_reg;
                bus.o_byte_valid = 1'b1;
                if (bus.i_byte_ready) state_nxt = (cnt_inc == len) ? DONE : FETCH;
            end
            DONE: begin
                o_tx_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One counter walks the preamble, then is reused as the payload RAM address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            transmit_d <= 1'b0;
            len        <= '0;
            cnt        <= '0;
            byte_reg   <= '0;
        end else begin
            transmit_d <= i_transmit;
            case (state)
                IDLE: if (start) begin
                    len <= len_clamped;
                    cnt <= '0;
                end
                PRE:  if (bus.i_byte_ready) cnt <= last_pre ? '0 : cnt_inc;
                WAIT: byte_reg <= bus.i_ram_rdata;
                SEND: if (bus.i_byte_ready) cnt <= cnt_inc;
                default: ;
            endcase
        end
    end
endmodule
